// File: rtl/uart_tx_fifo_cfg_if.sv
// Host-side bundle of the UART transmitter: byte write handshake, frame
// configuration and the serial/status outputs.
interface uart_tx_fifo_cfg_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] baud_div;
  logic [1:0]       data_len;
  logic [1:0]       parity_mode;
  logic             stop2;
  logic             uart_tx;
  logic             tx_busy;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             tx_done;

  modport master (
    output in_data, in_valid, baud_div, data_len, parity_mode, stop2,
    input  in_ready, uart_tx, tx_busy, fifo_empty, fifo_count, tx_done
  );

  modport slave (
    input  in_data, in_valid, baud_div, data_len, parity_mode, stop2,
    output in_ready, uart_tx, tx_busy, fifo_empty, fifo_count, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a small FIFO; frame format (5-8 data bits, parity,
// 1/2 stop bits, divisor) is sampled per frame when the byte is popped.
module uart_tx_fifo_cfg #(
  parameter int unsigned CLK_FREQ    = 10_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DEFAULT_DIV = CLK_FREQ / BAUD_RATE,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DIV_W       = 16
) (
  input logic               clk,
  input logic               reset,
  uart_tx_fifo_cfg_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, load;

  logic [2:0]       state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       len_q, len_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             acc_q, acc_d;
  logic             stop_half_q, stop_half_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_end;
  logic             fifo_nonempty;
  logic [2:0]       last_idx;
  logic             par_en;

  assign push          = bus.in_valid && bus.in_ready;
  assign fifo_nonempty = (count_q != '0);
  assign bit_end       = (cnt_q == div_q - DIV_W'(1));
  assign last_idx      = 3'd4 + {1'b0, len_q};
  assign par_en        = (par_q == 2'b01) || (par_q == 2'b10);

  assign bus.in_ready   = (count_q != FULL_CNT);
  assign bus.fifo_empty = (count_q == '0);
  assign bus.fifo_count = count_q;
  assign bus.uart_tx    = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    len_d       = len_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    bit_idx_d   = bit_idx_q;
    acc_d       = acc_q;
    stop_half_d = stop_half_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load        = 1'b0;
    pop         = 1'b0;
    cnt_d       = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_nonempty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          acc_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx) begin
            if (par_en) begin
              state_d = S_PARITY;
              tx_d    = (par_q == 2'b10) ? ~acc_q : acc_q;
            end else begin
              state_d     = S_STOP;
              tx_d        = 1'b1;
              stop_half_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            acc_d     = acc_q ^ shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d     = S_STOP;
          tx_d        = 1'b1;
          stop_half_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_half_q) begin
            stop_half_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (fifo_nonempty) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Shared by IDLE and the final stop edge so back-to-back frames start
    // without an idle cycle; the frame format is captured here.
    if (load) begin
      pop         = 1'b1;
      state_d     = S_START;
      shift_d     = mem_q[rd_ptr_q];
      div_d       = (bus.baud_div == '0) ? DEF_DIV : bus.baud_div;
      len_d       = bus.data_len;
      par_d       = bus.parity_mode;
      stop2_d     = bus.stop2;
      cnt_d       = '0;
      bit_idx_d   = 3'd0;
      acc_d       = 1'b0;
      stop_half_d = 1'b0;
      tx_d        = 1'b0;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      shift_q     <= '0;
      div_q       <= DEF_DIV;
      cnt_q       <= '0;
      len_q       <= '0;
      par_q       <= '0;
      stop2_q     <= 1'b0;
      bit_idx_q   <= '0;
      acc_q       <= 1'b0;
      stop_half_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      bit_idx_q   <= bit_idx_d;
      acc_q       <= acc_d;
      stop_half_q <= stop_half_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg: a line monitor decodes every frame
// against expectations queued at write time.
module tb_uart_tx_fifo_cfg;
  localparam int unsigned FD    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEF_D = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_cfg_if #(.FIFO_DEPTH(FD), .DIV_W(DW)) bus ();

  uart_tx_fifo_cfg #(
    .CLK_FREQ(1000), .BAUD_RATE(200), .FIFO_DEPTH(FD), .DIV_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned d;
    logic [1:0]  len;
    logic [1:0]  par;
    logic        st;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned done_pulses = 0;
  int unsigned frames_expected = 0;
  int unsigned last_acc_cyc = 0;
  int unsigned last_done_cyc = 0;

  logic        mon_active = 1'b0;
  exp_t        cur;
  logic [11:0] cur_bits;
  int unsigned cur_n, cur_d, k;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected line levels for one frame, one entry per bit period.
  function automatic int unsigned build(input exp_t e, output logic [11:0] v);
    int unsigned n, len;
    logic p;
    v   = '1;
    v[0] = 1'b0;
    p   = 1'b0;
    n   = 1;
    len = 5 + int'(e.len);
    for (int unsigned i = 0; i < len; i++) begin
      v[n] = e.data[i];
      p    = p ^ e.data[i];
      n++;
    end
    if (e.par == 2'b01) begin
      v[n] = p;
      n++;
    end else if (e.par == 2'b10) begin
      v[n] = ~p;
      n++;
    end
    n = n + 1 + int'(e.st);
    return n;
  endfunction

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      mon_active = 1'b0;
    end else begin
      if (bus.tx_done === 1'b1) done_pulses++;
      if (mon_active && k == cur_n * cur_d) begin
        chk("done_at_frame_end", bus.tx_done, 1);
        last_done_cyc = cyc;
        mon_active = 1'b0;
      end
      if (!mon_active && bus.uart_tx === 1'b0) begin
        chk("start_has_expectation", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur        = exp_q.pop_front();
          cur_n      = build(cur, cur_bits);
          cur_d      = cur.d;
          k          = 0;
          mon_active = 1'b1;
        end
      end
      if (mon_active) begin
        chk("line_bit", bus.uart_tx, cur_bits[k / cur_d]);
        chk("busy_in_frame", bus.tx_busy, 1);
        if (k != 0) chk("no_early_done", bus.tx_done, 0);
        k++;
      end
    end
  end

  task automatic cfg(input logic [DW-1:0] div, input logic [1:0] len,
                     input logic [1:0] par, input logic st);
    @(negedge clk);
    bus.baud_div    = div;
    bus.data_len    = len;
    bus.parity_mode = par;
    bus.stop2       = st;
  endtask

  task automatic write_byte(input logic [7:0] b, input int unsigned d);
    int unsigned g;
    exp_t e;
    g = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("write_accept_timeout", 32'(g < 2000), 1);
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    bus.in_valid = 1'b0;
    e.data = b;
    e.d    = d;
    e.len  = bus.data_len;
    e.par  = bus.parity_mode;
    e.st   = bus.stop2;
    exp_q.push_back(e);
    frames_expected++;
  endtask

  task automatic drain(input string tag);
    int unsigned g;
    g = 0;
    while ((exp_q.size() != 0 || mon_active || bus.tx_busy !== 1'b0) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk(tag, 32'(g < 5000), 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  burst [5];
    int unsigned c0, p0;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.baud_div    = 16'd4;
    bus.data_len    = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop2       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", bus.uart_tx, 1);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_tx_done", bus.tx_done, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_fifo_empty", bus.fifo_empty, 1);
    chk("rst_in_ready", bus.in_ready, 1);
    #2 reset = 1'b0;

    // 0x55 8N1 at 4 clk/bit, including write-to-start latency
    cfg(16'd4, 2'b11, 2'b00, 1'b0);
    write_byte(8'h55, 4);
    @(negedge clk);
    chk("lat_line_still_idle", bus.uart_tx, 1);
    chk("lat_count_one", bus.fifo_count, 1);
    @(negedge clk);
    chk("lat_start_low", bus.uart_tx, 0);
    chk("lat_busy", bus.tx_busy, 1);
    chk("lat_popped", bus.fifo_count, 0);
    drain("drain_8n1");
    chk("busy_low_after", bus.tx_busy, 0);
    chk("done_count_8n1", done_pulses, frames_expected);

    // 5 bits, even parity, two stop bits, upper bits dropped
    cfg(16'd3, 2'b00, 2'b01, 1'b1);
    write_byte(8'hFF, 3);
    drain("drain_5e2");

    // 7 bits odd then even parity of zero data
    cfg(16'd2, 2'b10, 2'b10, 1'b0);
    write_byte(8'h00, 2);
    drain("drain_7o1");
    cfg(16'd2, 2'b10, 2'b01, 1'b0);
    write_byte(8'h00, 2);
    drain("drain_7e1");

    // Burst fills the FIFO; frames run back to back
    cfg(16'd2, 2'b11, 2'b00, 1'b0);
    p0 = done_pulses;
    for (int i = 0; i < 5; i++) begin
      write_byte(burst[i], 2);
      if (i == 0) c0 = last_acc_cyc;
    end
    @(negedge clk);
    chk("burst_in_ready_full", bus.in_ready, 0);
    chk("burst_count_full", bus.fifo_count, 4);
    bus.in_data  = 8'h66;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("write_when_full_ignored", bus.fifo_count, 4);
    drain("drain_burst");
    chk("burst_span", last_done_cyc - c0, 101);
    chk("burst_done_pulses", done_pulses - p0, 5);
    chk("burst_fifo_empty", bus.fifo_empty, 1);

    // Divisor change mid-frame only affects the next frame
    cfg(16'd4, 2'b11, 2'b00, 1'b0);
    write_byte(8'hA5, 4);
    write_byte(8'h3C, 8);
    repeat (10) @(negedge clk);
    bus.baud_div = 16'd8;
    drain("drain_div_change");

    // D=1 with parity_mode 11 (none), then the default divisor
    cfg(16'd1, 2'b01, 2'b11, 1'b0);
    write_byte(8'h2A, 1);
    write_byte(8'h15, 1);
    drain("drain_div1");
    cfg(16'd0, 2'b11, 2'b10, 1'b1);
    write_byte(8'h81, DEF_D);
    drain("drain_default_div");

    // Reset during DATA with two bytes still queued
    cfg(16'd4, 2'b11, 2'b00, 1'b0);
    write_byte(8'hC3, 4);
    write_byte(8'h5A, 4);
    write_byte(8'h96, 4);
    repeat (8) @(negedge clk);
    chk("pre_reset_busy", bus.tx_busy, 1);
    p0 = done_pulses;
    #2 reset = 1'b1;
    exp_q.delete();
    frames_expected = frames_expected - 3;
    #1;
    chk("abort_uart_tx", bus.uart_tx, 1);
    chk("abort_fifo_count", bus.fifo_count, 0);
    chk("abort_tx_busy", bus.tx_busy, 0);
    chk("abort_tx_done", bus.tx_done, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_after_reset", bus.uart_tx, 1);
    end
    chk("no_done_after_abort", done_pulses, p0);
    chk("total_done_pulses", done_pulses, frames_expected);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
